// File: rtl/two_req_rr_arbiter_if.sv
// Handshake bundle between two producers (A, B), the arbiter and one consumer (Z).
// The arbiter uses the slave view. The producer/consumer side uses the master view.
interface two_req_rr_arbiter_if #(
  parameter int W = 8
);
  logic         a_valid;
  logic [W-1:0] a_data;
  logic         a_ready;
  logic         b_valid;
  logic [W-1:0] b_data;
  logic         b_ready;
  logic         z_valid;
  logic [W-1:0] z_data;
  logic         z_ready;

  modport slave (
    input  a_valid, a_data, b_valid, b_data, z_ready,
    output a_ready, b_ready, z_valid, z_data
  );

  modport master (
    output a_valid, a_data, b_valid, b_data, z_ready,
    input  a_ready, b_ready, z_valid, z_data
  );
endinterface

// File: rtl/two_req_rr_arbiter.sv
// Two-way round-robin arbiter with a burst limit of MAX_BEATS accepted beats per grant.
// The data path is a purely combinational 2:1 mux, and the handshakes are gated by the owner state.
module two_req_rr_arbiter #(
  parameter int W         = 8,
  parameter int MAX_BEATS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  two_req_rr_arbiter_if.slave     bus,
  output logic                    sel,
  output logic                    busy
);
  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BEATS - 1);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_e;

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          a_rdy, b_rdy, z_vld, beat, release_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    sel           = last_q;
    z_vld         = 1'b0;
    a_rdy         = 1'b0;
    b_rdy         = 1'b0;
    beat          = 1'b0;
    release_grant = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.a_valid && bus.b_valid) state_d = last_q ? OWN_A : OWN_B;
        else if (bus.a_valid)           state_d = OWN_A;
        else if (bus.b_valid)           state_d = OWN_B;
      end
      OWN_A: begin
        sel           = 1'b0;
        z_vld         = bus.a_valid;
        a_rdy         = bus.z_ready;
        beat          = bus.a_valid && bus.z_ready;
        release_grant = !bus.a_valid || (beat && (cnt_q == LAST_BEAT));
        if (release_grant) begin
          // Re-arbitrate immediately with A demoted so B never sees a bubble.
          last_d = 1'b0;
          cnt_d  = '0;
          if (bus.b_valid)      state_d = OWN_B;
          else if (bus.a_valid) state_d = OWN_A;
          else                  state_d = IDLE;
        end else if (beat) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      OWN_B: begin
        sel           = 1'b1;
        z_vld         = bus.b_valid;
        b_rdy         = bus.z_ready;
        beat          = bus.b_valid && bus.z_ready;
        release_grant = !bus.b_valid || (beat && (cnt_q == LAST_BEAT));
        if (release_grant) begin
          last_d = 1'b1;
          cnt_d  = '0;
          if (bus.a_valid)      state_d = OWN_A;
          else if (bus.b_valid) state_d = OWN_B;
          else                  state_d = IDLE;
        end else if (beat) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Readies are masked during reset so no beat is accepted in that cycle.
  assign bus.a_ready = a_rdy && !rst;
  assign bus.b_ready = b_rdy && !rst;
  assign bus.z_valid = z_vld;
  assign bus.z_data  = sel ? bus.b_data : bus.a_data;
  assign busy        = (state_q != IDLE);
endmodule

// File: tb/tb_two_req_rr_arbiter.sv
// Directed bench for two_req_rr_arbiter (W=8, MAX_BEATS=4); one task per scenario.
module tb_two_req_rr_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sel, busy;
  int   checks = 0;
  int   errors = 0;

  two_req_rr_arbiter_if #(.W(8)) bus ();

  two_req_rr_arbiter #(.W(8), .MAX_BEATS(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .sel  (sel),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.a_valid = 1'b0; bus.b_valid = 1'b0; bus.z_ready = 1'b0;
    bus.a_data = 8'h00; bus.b_data = 8'h00;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.a_valid = 1'b1; bus.b_valid = 1'b1; bus.z_ready = 1'b1;
    bus.a_data = 8'h11; bus.b_data = 8'h22;
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      checks++;
      if ({bus.a_ready, bus.b_ready, bus.z_valid, busy, sel} !== 5'b00001) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: a_rdy/b_rdy/z_vld/busy/sel got %b want 00001", i,
                 {bus.a_ready, bus.b_ready, bus.z_valid, busy, sel});
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.a_ready, bus.b_ready, bus.z_valid, busy, sel} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_release_idle: got %b want 00001",
               {bus.a_ready, bus.b_ready, bus.z_valid, busy, sel});
    end
    next_cycle();
    checks++;
    if ({busy, sel, bus.a_ready, bus.b_ready, bus.z_valid} !== 5'b10101) begin
      errors++;
      $display("FAIL reset_first_grant: busy/sel/a_rdy/b_rdy/z_vld got %b want 10101",
               {busy, sel, bus.a_ready, bus.b_ready, bus.z_valid});
    end
  endtask

  task automatic test_single_burst();
    logic [7:0] exp_data;
    do_reset();
    bus.a_valid = 1'b1; bus.b_valid = 1'b0; bus.z_ready = 1'b1; bus.a_data = 8'h11;
    #1;
    checks++;
    if (bus.z_valid !== 1'b0 || bus.a_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_idle_cycle: z_vld=%b a_rdy=%b want 0 0", bus.z_valid, bus.a_ready);
    end
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      exp_data = 8'(8'h11 * (k + 1));
      bus.a_data = exp_data;
      #1;
      checks++;
      if (bus.z_valid !== 1'b1 || bus.z_data !== exp_data || bus.a_ready !== 1'b1 ||
          bus.b_ready !== 1'b0 || sel !== 1'b0 || busy !== 1'b1 ||
          dut.cnt_q !== 3'(k % 4)) begin
        errors++;
        $display("FAIL single_beat%0d: z_vld=%b z_data=%h a_rdy=%b b_rdy=%b sel=%b busy=%b cnt=%0d want 1 %h 1 0 0 1 %0d",
                 k, bus.z_valid, bus.z_data, bus.a_ready, bus.b_ready, sel, busy, dut.cnt_q,
                 exp_data, k % 4);
      end
    end
  endtask

  task automatic test_contention();
    logic exp_sel;
    do_reset();
    bus.a_valid = 1'b1; bus.b_valid = 1'b1; bus.z_ready = 1'b1;
    bus.a_data = 8'hAA; bus.b_data = 8'hBB;
    for (int i = 1; i <= 12; i++) begin
      next_cycle();
      exp_sel = (((i - 1) / 4) % 2) == 1;
      checks++;
      if (sel !== exp_sel || bus.z_valid !== 1'b1 || bus.z_data !== (exp_sel ? 8'hBB : 8'hAA) ||
          bus.a_ready !== !exp_sel || bus.b_ready !== exp_sel) begin
        errors++;
        $display("FAIL contention_cyc%0d: sel=%b z_vld=%b z_data=%h a_rdy=%b b_rdy=%b want sel=%b",
                 i, sel, bus.z_valid, bus.z_data, bus.a_ready, bus.b_ready, exp_sel);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.a_valid = 1'b1; bus.b_valid = 1'b1; bus.z_ready = 1'b0;
    bus.a_data = 8'hA5; bus.b_data = 8'h5B;
    for (int i = 1; i <= 7; i++) begin
      next_cycle();
      bus.z_ready = (i % 2) == 1;
      #1;
      checks++;
      if (sel !== 1'b0 || bus.z_data !== 8'hA5 || bus.a_ready !== bus.z_ready ||
          dut.cnt_q !== 3'(i / 2)) begin
        errors++;
        $display("FAIL backpressure_cyc%0d: sel=%b z_data=%h a_rdy=%b cnt=%0d want 0 a5 %b %0d",
                 i, sel, bus.z_data, bus.a_ready, dut.cnt_q, bus.z_ready, i / 2);
      end
    end
    next_cycle();
    checks++;
    if (sel !== 1'b1 || bus.z_data !== 8'h5B || dut.cnt_q !== 3'd0 || dut.last_q !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_switch: sel=%b z_data=%h cnt=%0d last=%b want 1 5b 0 0",
               sel, bus.z_data, dut.cnt_q, dut.last_q);
    end
  endtask

  task automatic test_early_release();
    do_reset();
    bus.a_valid = 1'b1; bus.b_valid = 1'b1; bus.z_ready = 1'b1;
    bus.a_data = 8'h3C; bus.b_data = 8'hC3;
    next_cycle();
    next_cycle();
    checks++;
    if (sel !== 1'b0 || dut.cnt_q !== 3'd1) begin
      errors++;
      $display("FAIL early_second_beat: sel=%b cnt=%0d want 0 1", sel, dut.cnt_q);
    end
    next_cycle();
    bus.a_valid = 1'b0;
    #1;
    checks++;
    if (bus.z_valid !== 1'b0 || dut.cnt_q !== 3'd2) begin
      errors++;
      $display("FAIL early_drop_cycle: z_vld=%b cnt=%0d want 0 2", bus.z_valid, dut.cnt_q);
    end
    next_cycle();
    checks++;
    if (sel !== 1'b1 || busy !== 1'b1 || dut.last_q !== 1'b0 || dut.cnt_q !== 3'd0 ||
        bus.b_ready !== 1'b1 || bus.z_data !== 8'hC3) begin
      errors++;
      $display("FAIL early_own_b: sel=%b busy=%b last=%b cnt=%0d b_rdy=%b z_data=%h want 1 1 0 0 1 c3",
               sel, busy, dut.last_q, dut.cnt_q, bus.b_ready, bus.z_data);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    bus.a_valid = 1'b1; bus.b_valid = 1'b0; bus.z_ready = 1'b1; bus.a_data = 8'h77;
    next_cycle();
    next_cycle();
    next_cycle();
    rst = 1'b1;
    #1;
    checks++;
    if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0 || dut.cnt_q !== 3'd2) begin
      errors++;
      $display("FAIL midrst_no_accept: a_rdy=%b b_rdy=%b cnt=%0d want 0 0 2",
               bus.a_ready, bus.b_ready, dut.cnt_q);
    end
    next_cycle();
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || dut.last_q !== 1'b1 || dut.cnt_q !== 3'd0 || sel !== 1'b1 ||
        bus.a_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_idle: busy=%b last=%b cnt=%0d sel=%b a_rdy=%b want 0 1 0 1 0",
               busy, dut.last_q, dut.cnt_q, sel, bus.a_ready);
    end
  endtask

  initial begin
    bus.a_valid = 1'b0; bus.b_valid = 1'b0; bus.z_ready = 1'b0;
    bus.a_data = 8'h00; bus.b_data = 8'h00;
    test_reset();
    test_single_burst();
    test_contention();
    test_backpressure();
    test_early_release();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
